spi_ram_ctrl: RTL

Parametrised command-driven RAM behind the SPI slave front end, successor to the fixed 8-bit register memory. It decodes (DATA_W+2)-bit command words from the deserialiser into address-load, write and read operations. Read data goes back to the serialiser over a valid/ready handshake, and the block adds optional pointer auto-increment for bursts plus range and overrun error flags.

---
 rtl/spi_ram_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl: command-driven word RAM behind the SPI slave front end.
// Decodes (DATA_W+2)-bit command words into write-pointer load, write,
// read-pointer load and read-request operations. Read data is returned
// to the serialiser over a valid/ready handshake.
//
// Optional feature macro: SPI_RAM_AUTO_INC_EN
//   defined   -> wr_ptr/rd_ptr post-increment (wrapping at MEM_DEPTH-1)
//                after each accepted write / read request
//   undefined -> pointers change only through pointer-load commands
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     synchronous active-low reset
//   din       command word: opcode din[DATA_W+1:DATA_W], payload din[DATA_W-1:0]
//   rx_valid  din valid this cycle
//   tx_ready  serialiser accepts dout this cycle
//   dout      registered read data
//   tx_valid  dout valid, held until accepted
//   addr_err  sticky: out-of-range pointer load seen
//   rd_drop   sticky: read request dropped while a read was pending
module spi_ram_ctrl #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W+1:0] din,
  input  logic              rx_valid,
  input  logic              tx_ready,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid,
  output logic              addr_err,
  output logic              rd_drop
);

  localparam int unsigned EXT_W = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
  localparam int unsigned CMP_W = EXT_W + 1;
  localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [1:0] OP_WR_PTR = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_RD_PTR = 2'b10;
  localparam logic [1:0] OP_READ   = 2'b11;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

`ifdef SPI_RAM_AUTO_INC_EN
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

  // Pointer post-increment with wrap at the top of the array
  function automatic logic [ADDR_W-1:0] f_inc(input logic [ADDR_W-1:0] p);
    return (p == LAST_ADDR) ? '0 : ADDR_W'(p + 1'b1);
  endfunction
`endif

  logic [DATA_W-1:0] r_mem [MEM_DEPTH];
  logic [0:0]        r_state;
  logic [0:0]        w_next_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [DATA_W-1:0] r_dout;
  logic              r_tx_valid;
  logic              r_addr_err;
  logic              r_rd_drop;

  logic [1:0]        w_op;
  logic [DATA_W-1:0] w_payload;
  logic [EXT_W-1:0]  w_payload_ext;
  logic [ADDR_W-1:0] w_addr_val;
  logic              w_addr_ok;
  logic              w_wr_ptr_ld;
  logic              w_rd_ptr_ld;
  logic              w_addr_bad;
  logic              w_wr_en;
  logic              w_is_read;
  logic              w_rd_accept;
  logic              w_rd_drop;

  // Command decode; payload is widened so any bit above ADDR_W fails the range test
  assign w_op          = din[DATA_W+1:DATA_W];
  assign w_payload     = din[DATA_W-1:0];
  assign w_payload_ext = EXT_W'(w_payload);
  assign w_addr_val    = ADDR_W'(w_payload_ext);
  assign w_addr_ok     = ({1'b0, w_payload_ext} < CMP_W'(MEM_DEPTH));

  assign w_wr_ptr_ld = rx_valid && (w_op == OP_WR_PTR) && w_addr_ok;
  assign w_rd_ptr_ld = rx_valid && (w_op == OP_RD_PTR) && w_addr_ok;
  assign w_addr_bad  = rx_valid && ((w_op == OP_WR_PTR) || (w_op == OP_RD_PTR)) && !w_addr_ok;
  assign w_wr_en     = rx_valid && (w_op == OP_WRITE);
  assign w_is_read   = rx_valid && (w_op == OP_READ);

  // Read FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Read FSM next state; a new request in HOLD is only taken when the
  // pending word leaves on the same edge, otherwise it is dropped
  always_comb begin
    w_next_state = r_state;
    w_rd_accept  = 1'b0;
    w_rd_drop    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_is_read) begin
          w_rd_accept  = 1'b1;
          w_next_state = S_HOLD;
        end
      end
      S_HOLD: begin
        if (w_is_read) begin
          if (tx_ready) begin
            w_rd_accept = 1'b1;
          end else begin
            w_rd_drop = 1'b1;
          end
        end else if (tx_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Pointers, read data and sticky flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_dout     <= '0;
      r_tx_valid <= 1'b0;
      r_addr_err <= 1'b0;
      r_rd_drop  <= 1'b0;
    end else begin
      r_tx_valid <= (w_next_state == S_HOLD);
      if (w_rd_accept) r_dout <= r_mem[IDX_W'(r_rd_ptr)];
      if (w_addr_bad)  r_addr_err <= 1'b1;
      if (w_rd_drop)   r_rd_drop <= 1'b1;
      if (w_wr_ptr_ld) r_wr_ptr <= w_addr_val;
`ifdef SPI_RAM_AUTO_INC_EN
      else if (w_wr_en) r_wr_ptr <= f_inc(r_wr_ptr);
`endif
      if (w_rd_ptr_ld) r_rd_ptr <= w_addr_val;
`ifdef SPI_RAM_AUTO_INC_EN
      else if (w_rd_accept) r_rd_ptr <= f_inc(r_rd_ptr);
`endif
    end
  end

  // Storage array, intentionally not reset
  always_ff @(posedge clk) begin
    if (rst_n && w_wr_en) begin
      r_mem[IDX_W'(r_wr_ptr)] <= w_payload;
    end
  end

  assign dout     = r_dout;
  assign tx_valid = r_tx_valid;
  assign addr_err = r_addr_err;
  assign rd_drop  = r_rd_drop;

endmodule
